// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised synchronous up/down counter with runtime-programmable terminal
// value. It counts 0..M (modulus M+1) in either direction and provides a
// parallel load, a synchronous clear, a ripple-cascade output and a registered
// wrap pulse. With M = 2^WIDTH-1 and UD = 1 it behaves as a plain binary
// counter, matching the earlier 4-bit 161-style part.
//
// Parameters:
//   WIDTH  counter width in bits (>= 1)
//
// Ports:
//   CP   in   clock, all state changes on its rising edge
//   CR   in   synchronous active-high clear, highest priority
//   D    in   parallel load data
//   M    in   terminal value of the count sequence
//   Ld   in   synchronous parallel load, active-low
//   CTT  in   count enable T, also gates Co (cascade input)
//   CTP  in   count enable P
//   UD   in   direction, 1 = up, 0 = down
//   Q    out  registered count value
//   Co   out  combinational terminal-count / cascade output
//   Wr   out  registered one-cycle pulse following an actual wrap
// -----------------------------------------------------------------------------
module param_updown_counter #(
   parameter int WIDTH = 4
) (
   input  logic             CP,
   input  logic             CR,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] M,
   input  logic             Ld,
   input  logic             CTT,
   input  logic             CTP,
   input  logic             UD,
   output logic [WIDTH-1:0] Q,
   output logic             Co,
   output logic             Wr
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             wr_reg;
   logic             wr_next;

   logic             at_zero;
   logic             at_term;
   logic             above_term;

   assign at_zero    = (q_reg == '0);
   assign at_term    = (q_reg == M);
   assign above_term = (q_reg > M);

   // Next-state selection. Clear and load are resolved in the register
   // process; this block only covers counting and holding.
   always_comb begin
      q_next  = q_reg;
      wr_next = 1'b0;
      if (CTT && CTP) begin
         if (UD) begin
            // Up: reaching or exceeding the terminal value wraps to zero.
            if (at_term || above_term) begin
               q_next  = '0;
               wr_next = 1'b1;
            end else begin
               q_next = q_reg + 1'b1;
            end
         end else begin
            // Down: zero wraps to M. A value above M (e.g. after a load
            // of D > M or a lowered M) snaps back to M without flagging
            // a wrap, since no full cycle was completed.
            if (at_zero) begin
               q_next  = M;
               wr_next = 1'b1;
            end else if (above_term) begin
               q_next = M;
            end else begin
               q_next = q_reg - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CP) begin
      if (CR) begin
         q_reg  <= '0;
         wr_reg <= 1'b0;
      end else if (!Ld) begin
         q_reg  <= D;
         wr_reg <= 1'b0;
      end else begin
         q_reg  <= q_next;
         wr_reg <= wr_next;
      end
   end

   // Co ignores CTP so a chain of stages ripples through the CTT inputs.
   assign Co = CTT & (UD ? at_term : at_zero);
   assign Q  = q_reg;
   assign Wr = wr_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // ---------------- main WIDTH=4 instance ----------------
   logic       cr, ld, ctt, ctp, ud;
   logic [3:0] d4, m4, q4;
   logic       co4, wr4;

   param_updown_counter #(.WIDTH(4)) u_main (
      .CP(clk), .CR(cr), .D(d4), .M(m4), .Ld(ld), .CTT(ctt), .CTP(ctp),
      .UD(ud), .Q(q4), .Co(co4), .Wr(wr4)
   );

   // ---------------- two-stage cascade ----------------
   logic       cr_c;
   logic [3:0] ql, qh;
   logic       col, coh, wrl, wrh;
   logic [3:0] m15 = 4'd15;
   logic [3:0] dz  = 4'd0;

   param_updown_counter #(.WIDTH(4)) u_lo (
      .CP(clk), .CR(cr_c), .D(dz), .M(m15), .Ld(1'b1), .CTT(1'b1), .CTP(1'b1),
      .UD(1'b1), .Q(ql), .Co(col), .Wr(wrl)
   );
   param_updown_counter #(.WIDTH(4)) u_hi (
      .CP(clk), .CR(cr_c), .D(dz), .M(m15), .Ld(1'b1), .CTT(col), .CTP(1'b1),
      .UD(1'b1), .Q(qh), .Co(coh), .Wr(wrh)
   );

   // ---------------- WIDTH=1 instance ----------------
   logic cr1, q1, co1, wr1;
   logic d1 = 1'b0;
   logic m1 = 1'b1;

   param_updown_counter #(.WIDTH(1)) u_w1 (
      .CP(clk), .CR(cr1), .D(d1), .M(m1), .Ld(1'b1), .CTT(1'b1), .CTP(1'b1),
      .UD(1'b1), .Q(q1), .Co(co1), .Wr(wr1)
   );

   // ---------------- WIDTH=8 instance ----------------
   logic       cr8, ld8;
   logic [7:0] d8, m8, q8;
   logic       co8, wr8;

   param_updown_counter #(.WIDTH(8)) u_w8 (
      .CP(clk), .CR(cr8), .D(d8), .M(m8), .Ld(ld8), .CTT(1'b1), .CTP(1'b1),
      .UD(1'b1), .Q(q8), .Co(co8), .Wr(wr8)
   );

   // ---------------- reference model for the main instance ----------------
   int mq = 0;
   int mwr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural step: priority clear > load > count > hold, counting over
   // the closed range 0..M with the out-of-range rules of the block.
   task automatic tick4(input string tag);
      int nq, nw;
      int m;
      m  = int'(m4);
      nq = mq;
      nw = 0;
      if (cr) begin
         nq = 0;
      end else if (!ld) begin
         nq = int'(d4);
      end else if (ctt && ctp) begin
         if (ud) begin
            if (mq >= m) begin nq = 0; nw = 1; end
            else nq = mq + 1;
         end else begin
            if (mq == 0) begin nq = m; nw = 1; end
            else if (mq > m) nq = m;
            else nq = mq - 1;
         end
      end
      cyc();
      mq  = nq;
      mwr = nw;
      $display("[%0t] %s: Q=%0d Wr=%0d (exp Q=%0d Wr=%0d)", $time, tag, q4, wr4, mq, mwr);
      chk({tag, ".Q"}, 32'(q4), 32'(mq));
      chk({tag, ".Wr"}, 32'(wr4), 32'(mwr));
   endtask

   task automatic chk_co(input string tag);
      int e;
      e = (ctt && (ud ? (mq == int'(m4)) : (mq == 0))) ? 1 : 0;
      #1;
      chk({tag, ".Co"}, 32'(co4), 32'(e));
   endtask

   initial begin
      int wcnt;
      cr = 1; ld = 0; d4 = 4'd9; m4 = 4'd9; ctt = 1; ctp = 1; ud = 1;
      cr_c = 1; cr1 = 1; cr8 = 1; ld8 = 1; d8 = 8'd0; m8 = 8'd0;

      // Reset beats load and enables
      tick4("reset_prio");
      chk_co("reset_up");
      ud = 0; chk_co("reset_down"); ud = 1;
      cr = 0;
      tick4("load9");
      // Clear, then mod-10 up count for 12 edges
      ld = 1; cr = 1;
      tick4("clear");
      cr = 0;
      for (int i = 0; i < 12; i++) begin
         chk_co("mod10");
         tick4("mod10");
      end
      // Q=9 with CTT=0 -> Co=0 and hold
      ld = 0; d4 = 4'd9; tick4("load9b"); ld = 1;
      chk_co("term_ctt1");
      ctt = 0;
      chk_co("term_ctt0");
      tick4("hold_ctt0");
      ctt = 1;

      // Down with wrap and recovery
      m4 = 4'd5; ld = 0; d4 = 4'd1; tick4("load1"); ld = 1; ud = 0;
      for (int i = 0; i < 3; i++) begin
         chk_co("down");
         tick4("down");
      end
      ld = 0; d4 = 4'd12; tick4("load12"); ld = 1;
      chk_co("above_m");
      tick4("recover");

      // Enable gating
      ctp = 0;
      for (int i = 0; i < 2; i++) begin
         chk_co("gate");
         tick4("gate");
      end
      ctt = 0; chk_co("gate_ctt0"); ctp = 1;
      tick4("gate_ctt0");

      // Randomized run against the model
      for (int i = 0; i < 200; i++) begin
         cr  = ($urandom_range(0, 19) == 0);
         ld  = ($urandom_range(0, 7) != 0);
         ctt = ($urandom_range(0, 3) != 0);
         ctp = ($urandom_range(0, 3) != 0);
         ud  = $urandom_range(0, 1) != 0;
         m4  = 4'($urandom_range(0, 15));
         d4  = 4'($urandom_range(0, 15));
         chk_co("rand");
         tick4("rand");
      end

      // Cascade: 8-bit value follows cycle count, high Wr only at 256
      cyc();
      cr_c = 0;
      wcnt = 0;
      for (int n = 1; n <= 300; n++) begin
         cyc();
         $display("[%0t] cascade n=%0d value=%0d wrh=%0d", $time, n, {qh, ql}, wrh);
         chk("cascade.value", 32'({qh, ql}), 32'(n % 256));
         chk("cascade.wrh", 32'(wrh), 32'(n == 256));
         if (wrh) wcnt++;
      end
      chk("cascade.wrh_count", 32'(wcnt), 32'd1);

      // WIDTH=1 toggles
      cr1 = 0;
      for (int n = 1; n <= 6; n++) begin
         cyc();
         $display("[%0t] w1 n=%0d Q=%0d Wr=%0d", $time, n, q1, wr1);
         chk("w1.Q", 32'(q1), 32'(n % 2));
         chk("w1.Wr", 32'(wr1), 32'(n > 1 && (n % 2) == 0));
      end

      // WIDTH=8, M=0: stays at 0, Wr every enabled cycle
      cr8 = 0;
      for (int n = 1; n <= 4; n++) begin
         cyc();
         $display("[%0t] w8 m0 Q=%0d Wr=%0d", $time, q8, wr8);
         chk("w8m0.Q", 32'(q8), 32'd0);
         chk("w8m0.Wr", 32'(wr8), 32'd1);
      end
      // WIDTH=8, M=255 from 254
      m8 = 8'd255; d8 = 8'd254; ld8 = 0;
      cyc();
      chk("w8.load", 32'(q8), 32'd254);
      ld8 = 1;
      cyc();
      $display("[%0t] w8 Q=%0d Wr=%0d", $time, q8, wr8);
      chk("w8.q255", 32'(q8), 32'd255);
      chk("w8.wr255", 32'(wr8), 32'd0);
      cyc();
      $display("[%0t] w8 Q=%0d Wr=%0d", $time, q8, wr8);
      chk("w8.wrap", 32'(q8), 32'd0);
      chk("w8.wrwrap", 32'(wr8), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
